// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 strip transmitter.
// GAMMA_LUT is only referenced when WS2812_GAMMA_EN is defined.
package ws2812_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, BIT, STALL, LATCH} state_t;

    localparam int PIX_W = 24;

    typedef logic [255:0][7:0] gamma_lut_t;

    // The strip expects green first; the producer delivers R,G,B.
    function automatic logic [PIX_W-1:0] rgb2grb(input logic [PIX_W-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    function automatic gamma_lut_t gamma_gen();
        gamma_lut_t lut;
        for (int i = 0; i < 256; i++)
            lut[i] = 8'($rtoi(255.0 * ((real'(i) / 255.0) ** 2.2) + 0.5));
        return lut;
    endfunction

    // gamma 2.2, rounded to nearest, evaluated at elaboration
    localparam gamma_lut_t GAMMA_LUT = gamma_gen();

endpackage

// File: rtl/ws2812_bit_enc.sv
// WS2812 NRZ bit encoder: 24-bit shifter, bit timer and latch timer.
// The timer is shared between bit slots and the latch low period.
module ws2812_bit_enc
    import ws2812_pkg::*;
#(
    parameter int T0H    = 40,
    parameter int T1H    = 80,
    parameter int TBIT   = 125,
    parameter int TRESET = 30000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic             latch,
    input  logic [PIX_W-1:0] word,
    output logic             dout,
    output logic             word_pre,
    output logic             word_done,
    output logic             latch_done
);
    localparam int TMAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int TW   = $clog2(TMAX);

    logic [TW-1:0]    tim;
    logic [4:0]       bit_cnt;
    logic [PIX_W-1:0] sh;
    logic             bit_done;
    logic             last_bit;

    assign last_bit   = (bit_cnt == 5'd23);
    assign bit_done   = run && (tim == TW'(TBIT - 1));
    // one cycle before the end of the last bit, so a reload can fill the final low slot
    assign word_pre   = run && last_bit && (tim == TW'(TBIT - 2));
    assign word_done  = bit_done && last_bit;
    assign latch_done = latch && (tim == TW'(TRESET - 1));
    assign dout       = run && (tim < (sh[PIX_W-1] ? TW'(T1H) : TW'(T0H)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
        end else if (load) begin
            sh      <= word;
            tim     <= '0;
            bit_cnt <= '0;
        end else if (run) begin
            if (bit_done) begin
                tim     <= '0;
                bit_cnt <= bit_cnt + 5'd1;
                sh      <= {sh[PIX_W-2:0], 1'b0};
            end else begin
                tim <= tim + 1'b1;
            end
        end else if (latch) begin
            tim <= latch_done ? '0 : tim + 1'b1;
        end else begin
            tim <= '0;
        end
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 strip transmitter: 4-phase pixel handshake, holding register plus shifter,
// frame latch. Define WS2812_GAMMA_EN to pass captured channels through a gamma LUT.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 39,
    parameter int T0H      = 40,
    parameter int T1H      = 80,
    parameter int TBIT     = 125,
    parameter int TRESET   = 30000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] avg_rgb,
    input  logic             trig,
    output logic             nxt,
    output logic             t_valid,
    output logic             rdy,
    output logic             dout,
    output logic             underrun
);
    localparam logic [7:0] NLED = 8'(NUM_LEDS);

    state_t           state, state_nxt;
    logic             trig_s1, trig_s2;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic             hold_full;
    logic [7:0]       cap_cnt, led_cnt;
    logic             cap_fire, hold_wr, pend;
    logic             enc_load, enc_run, enc_latch, led_inc;
    logic             word_pre, word_done, latch_done, led_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
        end
    end

    assign nxt      = !hold_full && !t_valid && !pend && (cap_cnt < NLED) && (state != LATCH);
    assign cap_fire = trig_s2 && nxt;
    assign led_last = (led_cnt >= NLED - 8'd1);

`ifdef WS2812_GAMMA_EN
    logic [PIX_W-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            pend    <= 1'b0;
        end else begin
            pend <= cap_fire;
            if (cap_fire) stage_q <= avg_rgb;
        end
    end

    assign hold_wr = pend;
    assign hold_d  = {GAMMA_LUT[stage_q[23:16]], GAMMA_LUT[stage_q[15:8]], GAMMA_LUT[stage_q[7:0]]};
`else
    assign pend    = 1'b0;
    assign hold_wr = cap_fire;
    assign hold_d  = avg_rgb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
            t_valid   <= 1'b0;
            cap_cnt   <= '0;
        end else begin
            if (hold_wr) begin
                hold_q  <= hold_d;
                t_valid <= 1'b1;
            end else if (!trig_s2 && t_valid) begin
                t_valid <= 1'b0;
                if (cap_cnt < NLED) cap_cnt <= cap_cnt + 8'd1;
            end
            if (enc_load) hold_full <= 1'b0;
            if (hold_wr)  hold_full <= 1'b1;
            if (latch_done) cap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led_cnt <= '0;
        else if (latch_done)
            led_cnt <= '0;
        else if (led_inc && led_cnt < NLED)
            led_cnt <= led_cnt + 8'd1;
    end

    // leaving reset goes through LATCH so a truncated frame still gets terminated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LATCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (hold_wr) state_nxt = LOAD;
            LOAD:  state_nxt = BIT;
            BIT: begin
                // back-to-back pixels: LOAD takes the last low cycle of bit 23
                if (word_pre && hold_full && !led_last)
                    state_nxt = LOAD;
                else if (word_done)
                    state_nxt = led_last ? LATCH : (hold_full ? LOAD : STALL);
            end
            STALL: if (hold_full) state_nxt = LOAD;
            LATCH: if (latch_done) state_nxt = IDLE;
            default: state_nxt = LATCH;
        endcase
    end

    always_comb begin
        rdy       = (state == IDLE);
        enc_load  = (state == LOAD);
        enc_run   = (state == BIT);
        enc_latch = (state == LATCH);
        led_inc   = (state == BIT) && (state_nxt != BIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underrun <= 1'b0;
        else        underrun <= (state == BIT) && (state_nxt == STALL);
    end

    ws2812_bit_enc #(
        .T0H   (T0H),
        .T1H   (T1H),
        .TBIT  (TBIT),
        .TRESET(TRESET)
    ) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (enc_load),
        .run       (enc_run),
        .latch     (enc_latch),
        .word      (rgb2grb(hold_q)),
        .dout      (dout),
        .word_pre  (word_pre),
        .word_done (word_done),
        .latch_done(latch_done)
    );

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: frame table, dout pulse decoder, reset/stall corners.
module tb_ws2812_tx;
    localparam int NUM_LEDS = 3;
    localparam int T0H      = 4;
    localparam int T1H      = 8;
    localparam int TBIT     = 12;
    localparam int TRESET   = 50;
`ifdef WS2812_GAMMA_EN
    localparam int TV_LAT = 4;
`else
    localparam int TV_LAT = 3;
`endif
    localparam int LIM = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] avg_rgb = '0;
    logic        trig = 1'b0;
    logic        nxt, t_valid, rdy, dout, underrun;

    ws2812_tx #(
        .NUM_LEDS(NUM_LEDS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .avg_rgb(avg_rgb), .trig(trig),
        .nxt(nxt), .t_valid(t_valid), .rdy(rdy), .dout(dout), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // dout pulse monitor, sampled on the falling edge
    typedef struct { int rise; int hi; } pulse_t;
    pulse_t pq[$];
    int   cyc = 0, hi = 0, rise_c = 0, rises = 0;
    int   tv_rises = 0, ur_cnt = 0, ur_cyc = 0, bad_hs = 0;
    logic pdout = 1'b0, ptv = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dout && !pdout) begin
            rise_c <= cyc + 1;
            hi     <= 1;
            rises  <= rises + 1;
        end else if (dout) begin
            hi <= hi + 1;
        end else if (pdout) begin
            pq.push_back('{rise_c, hi});
        end
        if (t_valid && !ptv) tv_rises <= tv_rises + 1;
        if (underrun) begin
            ur_cnt <= ur_cnt + 1;
            ur_cyc <= cyc + 1;
        end
        if (nxt && t_valid) bad_hs <= bad_hs + 1;
        pdout <= dout;
        ptv   <= t_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [23:0] rgb;
        logic [23:0] grb;
        bit          eager;
        int          delay;
    } vec_t;
    vec_t vt[12];

`ifdef WS2812_GAMMA_EN
    function automatic logic [7:0] gam(input logic [7:0] x);
        return 8'($rtoi(255.0 * ((real'(x) / 255.0) ** 2.2) + 0.5));
    endfunction
    function automatic logic [23:0] exp_word(input logic [23:0] g);
        return {gam(g[23:16]), gam(g[15:8]), gam(g[7:0])};
    endfunction
`else
    function automatic logic [23:0] exp_word(input logic [23:0] g);
        return g;
    endfunction
`endif

    task automatic count_latch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rdy && n < LIM);
    endtask

    task automatic run_frame(input int f);
        int          tr[3];
        int          n, nxt_hi, tv_base, ur_base, stall_px, bad;
        logic [23:0] w;
        pq.delete();
        tv_base  = tv_rises;
        ur_base  = ur_cnt;
        stall_px = -1;
        for (int p = 0; p < 3; p++) begin
            vec_t v;
            v = vt[f*3+p];
            if (v.delay > 0) stall_px = p;
            if (!v.eager) begin
                n = 0;
                while (!nxt && n < LIM) begin tick(); n++; end
                check($sformatf("nxt_wait f%0d p%0d", f, p), n < LIM, 1);
                repeat (v.delay) tick();
            end
            avg_rgb = v.rgb;
            trig    = 1'b1;
            tr[p]   = cyc;
            n = 0;
            while (!t_valid && n < LIM) begin tick(); n++; end
            if (p == 0) check($sformatf("tvalid_lat f%0d", f), cyc - tr[0], TV_LAT);
            else        check($sformatf("tvalid_wait f%0d p%0d", f, p), t_valid, 1);
            trig = 1'b0;
            n = 0;
            while (t_valid && n < LIM) begin tick(); n++; end
        end
        nxt_hi = 0;
        n = 0;
        while (!rdy && n < LIM) begin
            if (nxt) nxt_hi++;
            tick();
            n++;
        end
        check($sformatf("rdy_wait f%0d", f), rdy, 1);
        check($sformatf("nxt_after_full f%0d", f), nxt_hi, 0);
        check($sformatf("tvalid_pulses f%0d", f), tv_rises - tv_base, 3);
        check($sformatf("underrun_cnt f%0d", f), ur_cnt - ur_base, (stall_px >= 0) ? 1 : 0);
        check($sformatf("bit_count f%0d", f), pq.size(), 3 * 24);
        if (pq.size() == 3 * 24) begin
            bad = 0;
            for (int p = 0; p < 3; p++) begin
                w = '0;
                for (int b = 0; b < 24; b++) begin
                    w = {w[22:0], pq[p*24+b].hi == T1H};
                    if (pq[p*24+b].hi != T0H && pq[p*24+b].hi != T1H) bad++;
                end
                check($sformatf("pixel_word f%0d p%0d", f, p), w, exp_word(vt[f*3+p].grb));
            end
            check($sformatf("pulse_widths f%0d", f), bad, 0);
            check($sformatf("first_rise_lat f%0d", f), pq[0].rise - tr[0], TV_LAT + 1);
            check($sformatf("latch_to_rdy f%0d", f), cyc - pq[71].rise, TBIT + TRESET);
            if (stall_px > 0) begin
                check($sformatf("underrun_at f%0d", f), ur_cyc - pq[(stall_px-1)*24].rise, 24 * TBIT);
                check($sformatf("stall_resume f%0d", f), pq[stall_px*24].rise - tr[stall_px], TV_LAT + 2);
            end else begin
                check($sformatf("frame_span f%0d", f), pq[71].rise - pq[0].rise, 3 * 24 * TBIT - TBIT);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, r0;
        vt[0]  = '{24'hFF0000, 24'h00FF00, 1'b0, 0};
        vt[1]  = '{24'h00FF00, 24'hFF0000, 1'b0, 0};
        vt[2]  = '{24'h0000FF, 24'h0000FF, 1'b0, 0};
        vt[3]  = '{24'h123456, 24'h341256, 1'b0, 0};
        vt[4]  = '{24'hA5C3E1, 24'hC3A5E1, 1'b0, 0};
        vt[5]  = '{24'h800001, 24'h008001, 1'b1, 0};
        vt[6]  = '{24'h5A5A5A, 24'h5A5A5A, 1'b0, 0};
        vt[7]  = '{24'h0F00F0, 24'h000FF0, 1'b0, 400};
        vt[8]  = '{24'hC0FFEE, 24'hFFC0EE, 1'b0, 0};
        vt[9]  = '{24'h010203, 24'h020103, 1'b0, 0};
        vt[10] = '{24'h7F8000, 24'h807F00, 1'b0, 0};
        vt[11] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 0};

        repeat (3) tick();
        check("reset_outputs", {dout, nxt, t_valid, rdy, underrun}, 0);
        r0 = rises;
        rst_n = 1'b1;
        count_latch(n);
        check("reset_latch_len", n, TRESET);
        check("latch_dout_low", rises - r0, 0);
        check("nxt_after_latch", nxt, 1);

        run_frame(0);
        run_frame(1);
        run_frame(2);

        // reset in the middle of a pixel
        avg_rgb = 24'hFFFFFF;
        trig    = 1'b1;
        n = 0;
        while (!t_valid && n < LIM) begin tick(); n++; end
        trig = 1'b0;
        repeat (100) tick();
        check("midpixel_busy", rdy, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {dout, nxt, t_valid, rdy, underrun}, 0);
        repeat (2) tick();
        r0 = rises;
        rst_n = 1'b1;
        count_latch(n);
        check("midreset_latch_len", n, TRESET);
        check("midreset_dout_low", rises - r0, 0);
        check("midreset_nxt", nxt, 1);
        run_frame(3);

        check("handshake_overlap", bad_hs, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
